// File: rtl/svm_mac_sequencer_if.sv
// Picker-side bus of the shared SVM evaluator: request, feature/weight/bias
// operands, stop handshake and the evaluation results.
interface svm_mac_sequencer_if #(
    parameter int N_FEATURES    = 11,
    parameter int FEATURE_WIDTH = 4,
    parameter int WEIGHT_WIDTH  = 8,
    parameter int BIAS_WIDTH    = 16,
    parameter int ACC_WIDTH     = 20
);
    logic                                  start;
    logic [FEATURE_WIDTH*N_FEATURES-1:0]   features;
    logic [WEIGHT_WIDTH*N_FEATURES-1:0]    weight;
    logic signed [BIAS_WIDTH-1:0]          bia;
    logic                                  stop;

    logic                                  busy;
    logic                                  svmready;
    logic                                  w_class;
    logic signed [ACC_WIDTH-1:0]           score;
    logic                                  done;
    logic                                  err;

    modport master (
        output start, features, weight, bia, stop,
        input  busy, svmready, w_class, score, done, err
    );

    modport slave (
        input  start, features, weight, bia, stop,
        output busy, svmready, w_class, score, done, err
    );
endinterface

// File: rtl/svm_mac_sequencer.sv
// Serial one-vs-one SVM evaluator: bias + sum(weight_i * feature_i) with one
// MAC per cycle, repeated per class pair until the picker stops or budget runs out.
module svm_mac_sequencer #(
    parameter int N_FEATURES    = 11,
    parameter int FEATURE_WIDTH = 4,
    parameter int WEIGHT_WIDTH  = 8,
    parameter int BIAS_WIDTH    = 16,
    parameter int ACC_WIDTH     = 20,
    parameter int MAX_EVALS     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    svm_mac_sequencer_if.slave   bus
);
    localparam int PROD_WIDTH = WEIGHT_WIDTH + FEATURE_WIDTH + 1;
    localparam int IDX_WIDTH  = (N_FEATURES > 1) ? $clog2(N_FEATURES) : 1;
    localparam int CNT_WIDTH  = $clog2(MAX_EVALS + 1);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX   = IDX_WIDTH'(N_FEATURES - 1);
    localparam logic [CNT_WIDTH-1:0] EVAL_LIMIT = CNT_WIDTH'(MAX_EVALS);

    typedef enum logic [1:0] {IDLE, ACCUM, EVAL, GAP} state_e;

    state_e                               state_q;
    logic [IDX_WIDTH-1:0]                 idx_q;
    logic [CNT_WIDTH-1:0]                 eval_cnt_q;
    logic signed [ACC_WIDTH-1:0]          acc_q;
    logic signed [ACC_WIDTH-1:0]          score_q;
    logic                                 w_class_q;
    logic                                 err_q;
    logic [FEATURE_WIDTH*N_FEATURES-1:0]  feat_q;

    logic signed [WEIGHT_WIDTH-1:0]       weight_arr [N_FEATURES];
    logic [FEATURE_WIDTH-1:0]             feat_arr   [N_FEATURES];
    logic signed [PROD_WIDTH-1:0]         prod;
    logic signed [ACC_WIDTH-1:0]          acc_d;
    logic signed [ACC_WIDTH-1:0]          bias_ext;

    for (genvar i = 0; i < N_FEATURES; i++) begin : g_unpack
        assign weight_arr[i] = bus.weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        assign feat_arr[i]   = feat_q[i*FEATURE_WIDTH +: FEATURE_WIDTH];
    end

    // Feature is zero-extended by one bit so the product stays a signed multiply.
    always_comb begin
        prod     = PROD_WIDTH'(weight_arr[idx_q])
                 * PROD_WIDTH'($signed({1'b0, feat_arr[idx_q]}));
        acc_d    = acc_q + ACC_WIDTH'(prod);
        bias_ext = ACC_WIDTH'(bus.bia);
    end

    // NOTE: state is assigned with <= so every register samples pre-edge values;
    // the latched feature vector is reset too, so nothing survives a mid-run reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            eval_cnt_q <= '0;
            acc_q      <= '0;
            score_q    <= '0;
            w_class_q  <= 1'b0;
            err_q      <= 1'b0;
            feat_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        feat_q     <= bus.features;
                        acc_q      <= bias_ext;
                        idx_q      <= '0;
                        eval_cnt_q <= '0;
                        err_q      <= 1'b0;
                        state_q    <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_d;
                    if (idx_q == LAST_IDX) begin
                        score_q   <= acc_d;
                        w_class_q <= ~acc_d[ACC_WIDTH-1];
                        state_q   <= EVAL;
                    end else begin
                        idx_q <= idx_q + IDX_WIDTH'(1);
                    end
                end
                EVAL: begin
                    eval_cnt_q <= eval_cnt_q + CNT_WIDTH'(1);
                    state_q    <= GAP;
                end
                GAP: begin
                    if (bus.stop) begin
                        state_q <= IDLE;
                    end else if (eval_cnt_q == EVAL_LIMIT) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        acc_q   <= bias_ext;
                        idx_q   <= '0;
                        state_q <= ACCUM;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // done must fall in the GAP cycle itself, so it qualifies the registered state with stop.
    assign bus.busy     = (state_q != IDLE);
    assign bus.svmready = (state_q == EVAL);
    assign bus.done     = (state_q == GAP) && bus.stop;
    assign bus.w_class  = w_class_q;
    assign bus.score    = score_q;
    assign bus.err      = err_q;
endmodule
